// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: FSM state encoding,
// ARM condition codes and NZCV flag bit positions.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_ADVANCE = 3'd4
    } state_t;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    // Bit positions inside the {N,Z,C,V} flag vector.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/pc_sequencer_cond_eval.sv
// Combinational ARM condition-field evaluator: returns 1 when the condition
// in instr_cond holds for the given NZCV flags. Code 15 never passes.
module cond_eval
    import pc_seq_pkg::*;
#(
    parameter int COND_W = 4
) (
    input  logic [COND_W-1:0] instr_cond,
    input  logic [COND_W-1:0] flags_nzcv,
    output logic              pass
);

    logic n, z, c, v;

    assign n = flags_nzcv[FLAG_N];
    assign z = flags_nzcv[FLAG_Z];
    assign c = flags_nzcv[FLAG_C];
    assign v = flags_nzcv[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (instr_cond[3:0])
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute/advance sequencer driving the PC controls.
// Optional performance counters are enabled by defining PC_SEQ_PERF_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int COND_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_ack,
    input  logic [COND_W-1:0] instr_cond,
    input  logic              instr_is_branch,
    input  logic              instr_to_link,
    input  logic              exec_done,
    input  logic [COND_W-1:0] flags_nzcv,
    output logic              fetch_req,
    output logic              decode_en,
    output logic              halt_temporarily_signal,
    output logic              should_branch,
    output logic              write_condition,
    output logic              should_branch_to_link,
`ifdef PC_SEQ_PERF_EN
    output logic [31:0]       stall_cycles,
    output logic [31:0]       instr_retired,
`endif
    output logic              busy
);

    localparam logic [2:0] S_IDLE    = ST_IDLE;
    localparam logic [2:0] S_FETCH   = ST_FETCH;
    localparam logic [2:0] S_DECODE  = ST_DECODE;
    localparam logic [2:0] S_EXECUTE = ST_EXECUTE;
    localparam logic [2:0] S_ADVANCE = ST_ADVANCE;

    logic [2:0]        state_reg;
    logic [2:0]        state_next;
    logic [COND_W-1:0] cond_reg;
    logic              is_branch_reg;
    logic              to_link_reg;
    logic              pass_reg;
    logic              cond_pass;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    state_next = S_FETCH;
            S_FETCH:   if (fetch_ack) state_next = S_DECODE;
            S_DECODE:  state_next = S_EXECUTE;
            S_EXECUTE: if (exec_done) state_next = S_ADVANCE;
            S_ADVANCE: state_next = S_FETCH;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    cond_eval #(
        .COND_W(COND_W)
    ) u_cond_eval (
        .instr_cond(cond_reg),
        .flags_nzcv(flags_nzcv),
        .pass      (cond_pass)
    );

    // Flags are sampled on the same edge that leaves EXECUTE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cond_reg      <= '0;
            is_branch_reg <= 1'b0;
            to_link_reg   <= 1'b0;
            pass_reg      <= 1'b0;
        end else begin
            if (state_reg == S_DECODE) begin
                cond_reg      <= instr_cond;
                is_branch_reg <= instr_is_branch;
                to_link_reg   <= instr_to_link;
            end
            if (state_reg == S_EXECUTE && exec_done) begin
                pass_reg <= cond_pass;
            end
        end
    end

    // Outputs depend only on state and registers, so the async reset
    // removes any advance window immediately.
    assign fetch_req               = (state_reg == S_FETCH);
    assign decode_en               = (state_reg == S_DECODE);
    assign halt_temporarily_signal = (state_reg != S_ADVANCE);
    assign busy                    = (state_reg != S_IDLE);
    assign should_branch           = (state_reg == S_ADVANCE) & is_branch_reg;
    assign write_condition         = (state_reg == S_ADVANCE) & pass_reg;
    assign should_branch_to_link   = (state_reg == S_ADVANCE) & to_link_reg;

`ifdef PC_SEQ_PERF_EN
    logic        in_wait_reg;
    logic [31:0] stall_reg;
    logic [31:0] retired_reg;

    // in_wait_reg is high from the second cycle of any state onward.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_wait_reg <= 1'b0;
            stall_reg   <= '0;
            retired_reg <= '0;
        end else begin
            in_wait_reg <= (state_next == state_reg);
            if ((state_reg == S_FETCH || state_reg == S_EXECUTE) && in_wait_reg
                && stall_reg != 32'hFFFF_FFFF) begin
                stall_reg <= stall_reg + 32'd1;
            end
            if (state_reg == S_ADVANCE) begin
                retired_reg <= retired_reg + 32'd1;
            end
        end
    end

    assign stall_cycles  = stall_reg;
    assign instr_retired = retired_reg;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed and randomized instructions
// checked cycle by cycle against a per-instruction timeline model.
module tb_pc_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       fetch_ack;
    logic [3:0] instr_cond;
    logic       instr_is_branch;
    logic       instr_to_link;
    logic       exec_done;
    logic [3:0] flags_nzcv;
    logic       fetch_req;
    logic       decode_en;
    logic       halt_temporarily_signal;
    logic       should_branch;
    logic       write_condition;
    logic       should_branch_to_link;
    logic       busy;
`ifdef PC_SEQ_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] instr_retired;
    logic [31:0] exp_stall;
    logic [31:0] exp_retired;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    pc_sequencer #(.COND_W(4)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .fetch_ack              (fetch_ack),
        .instr_cond             (instr_cond),
        .instr_is_branch        (instr_is_branch),
        .instr_to_link          (instr_to_link),
        .exec_done              (exec_done),
        .flags_nzcv             (flags_nzcv),
        .fetch_req              (fetch_req),
        .decode_en              (decode_en),
        .halt_temporarily_signal(halt_temporarily_signal),
        .should_branch          (should_branch),
        .write_condition        (write_condition),
        .should_branch_to_link  (should_branch_to_link),
`ifdef PC_SEQ_PERF_EN
        .stall_cycles           (stall_cycles),
        .instr_retired          (instr_retired),
`endif
        .busy                   (busy)
    );

    // Expected output vector {fetch_req, decode_en, halt, sb, wc, sbl, busy}.
    localparam logic [6:0] V_IDLE   = 7'b0010000;
    localparam logic [6:0] V_FETCH  = 7'b1010001;
    localparam logic [6:0] V_DECODE = 7'b0110001;
    localparam logic [6:0] V_EXEC   = 7'b0010001;

    function automatic logic [6:0] obs_vec();
        return {fetch_req, decode_en, halt_temporarily_signal, should_branch,
                write_condition, should_branch_to_link, busy};
    endfunction

    // ARM conditions come in complementary pairs: bit 0 inverts the base test.
    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic check7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        instr_cond      = 4'($urandom);
        instr_is_branch = 1'($urandom);
        instr_to_link   = 1'($urandom);
        flags_nzcv      = 4'($urandom);
    endtask

    // One instruction: FETCH f cycles, DECODE 1, EXECUTE e cycles, ADVANCE 1.
    // Called at a negedge where the DUT is in its first FETCH cycle.
    task automatic run_instr(input int f, input int e, input logic [3:0] c,
                             input logic [3:0] fl, input logic br, input logic lk,
                             input bit abort);
        logic wc;
        wc = cond_ref(c, fl);
`ifdef PC_SEQ_PERF_EN
        check32("stall_cycles", stall_cycles, exp_stall);
        check32("instr_retired", instr_retired, exp_retired);
`endif
        for (int j = 0; j < f; j++) begin
            check7("fetch", obs_vec(), V_FETCH);
            scramble();
            fetch_ack = (j == f - 1);
            exec_done = 1'b0;
            @(negedge clock);
        end
        check7("decode", obs_vec(), V_DECODE);
        instr_cond      = c;
        instr_is_branch = br;
        instr_to_link   = lk;
        flags_nzcv      = 4'($urandom);
        fetch_ack       = 1'($urandom);
        exec_done       = 1'b0;
        @(negedge clock);
        for (int j = 0; j < e; j++) begin
            check7("execute", obs_vec(), V_EXEC);
            scramble();
            fetch_ack = 1'($urandom);
            exec_done = (j == e - 1);
            if (j == e - 1) flags_nzcv = fl;
            @(negedge clock);
        end
        check7("advance", obs_vec(), {3'b000, br, wc, lk, 1'b1});
        $display("instr cond=%0d flags=%b br=%0b lk=%0b fetch=%0d exec=%0d -> sb=%0b wc=%0b sbl=%0b",
                 c, fl, br, lk, f, e, should_branch, write_condition, should_branch_to_link);
        if (abort) begin
            reset = 1'b1;
            #1;
            check7("reset_in_advance", obs_vec(), V_IDLE);
`ifdef PC_SEQ_PERF_EN
            exp_stall   = 32'd0;
            exp_retired = 32'd0;
`endif
            @(negedge clock);
            reset = 1'b0;
            #1;
            check7("idle_after_release", obs_vec(), V_IDLE);
            @(negedge clock);
        end else begin
            scramble();
            fetch_ack = 1'($urandom);
            exec_done = 1'b0;
            @(negedge clock);
`ifdef PC_SEQ_PERF_EN
            exp_stall   = exp_stall + 32'(f - 1) + 32'(e - 1);
            exp_retired = exp_retired + 32'd1;
`endif
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        reset           = 1'b1;
        fetch_ack       = 1'b0;
        exec_done       = 1'b0;
        instr_cond      = 4'd0;
        instr_is_branch = 1'b0;
        instr_to_link   = 1'b0;
        flags_nzcv      = 4'd0;
`ifdef PC_SEQ_PERF_EN
        exp_stall   = 32'd0;
        exp_retired = 32'd0;
`endif
        repeat (3) @(negedge clock);
        check7("reset_state", obs_vec(), V_IDLE);
        reset = 1'b0;
        #1;
        check7("idle_first", obs_vec(), V_IDLE);
        @(negedge clock);

        // Back-to-back minimum-length instructions.
        repeat (3) run_instr(1, 1, 4'd14, 4'($urandom), 1'b0, 1'b0, 1'b0);

        run_instr(1, 1, 4'd0, 4'b0100, 1'b1, 1'b0, 1'b0);
        run_instr(1, 1, 4'd0, 4'b0000, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            run_instr(1, 1, 4'd10, 4'(i), 1'b1, 1'b0, 1'b0);
        end
        repeat (3) run_instr(1, 1, 4'd15, 4'($urandom), 1'b1, 1'b0, 1'b0);
        repeat (3) run_instr(1, 1, 4'd14, 4'($urandom), 1'b1, 1'b0, 1'b0);

        run_instr(5, 3, 4'd14, 4'($urandom), 1'b0, 1'b0, 1'b0);

        run_instr(1, 1, 4'd14, 4'($urandom), 1'b1, 1'b1, 1'b0);

        run_instr(2, 2, 4'd14, 4'($urandom), 1'b1, 1'b1, 1'b1);

        repeat (40) begin
            run_instr(int'($urandom_range(1, 5)), int'($urandom_range(1, 5)),
                      4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end

        check7("final_fetch", obs_vec(), V_FETCH);
`ifdef PC_SEQ_PERF_EN
        check32("stall_cycles_final", stall_cycles, exp_stall);
        check32("instr_retired_final", instr_retired, exp_retired);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle control sequencer for the program counter. Runs the fetch / decode / execute / advance cycle, holds the PC frozen through `halt_temporarily_signal` except for exactly one advance window per instruction, and evaluates the ARM condition field against NZCV. It drives `should_branch`, `write_condition` and `should_branch_to_link` into the PC. It sits between instruction memory, the decoder and the PC, and is clocked on posedge so that the PC (negedge) sees stable controls.

## Interface
Parameters:
- `COND_W`, default 4: width of the condition field and of the flag vector.

Ports:
- `clock`, input, 1: single clock; FSM updates on posedge.
- `reset`, input, 1: asynchronous, active-high.
- `fetch_ack`, input, 1: instruction memory has returned the word addressed by the PC.
- `instr_cond`, input, 4: ARM cond field of the fetched instruction, sampled in DECODE.
- `instr_is_branch`, input, 1: fetched instruction is B/BL/BX class, sampled in DECODE.
- `instr_to_link`, input, 1: branch target is the link value, sampled in DECODE.
- `exec_done`, input, 1: datapath finished execution.
- `flags_nzcv`, input, 4: {N,Z,C,V} from the status register.
- `fetch_req`, output, 1: request instruction at the current PC.
- `decode_en`, output, 1: one-cycle strobe to latch the instruction register.
- `halt_temporarily_signal`, output, 1: 1 = PC frozen.
- `should_branch`, output, 1: latched branch flag, valid in ADVANCE.
- `write_condition`, output, 1: condition passed, valid in ADVANCE.
- `should_branch_to_link`, output, 1: latched link flag, valid in ADVANCE.
- `busy`, output, 1: 0 only in IDLE.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, ADVANCE.
- IDLE: entered on reset; moves to FETCH on the first posedge with `reset` low.
- FETCH:
  - `fetch_req` = 1.
  - `fetch_ack` high at a posedge moves to DECODE. An ack in the first FETCH cycle is accepted.
  - `fetch_ack` outside FETCH is ignored.
- DECODE:
  - Lasts one cycle; `decode_en` = 1.
  - Registers `instr_cond`, `instr_is_branch` and `instr_to_link`.
  - Moves to EXECUTE.
- EXECUTE:
  - Waits for `exec_done`; no timeout.
  - On the transition to ADVANCE, registers the condition result from `flags_nzcv` sampled at that same posedge.
- ADVANCE:
  - Lasts one cycle; `halt_temporarily_signal` = 0. Exactly one PC negedge falls inside this cycle.
  - Moves to FETCH.
- Condition evaluation:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V).
  - 14 AL = 1; 15 = 0 (treated as never).
- Outputs in ADVANCE:
  - `write_condition` = condition result.
  - `should_branch` = latched is_branch.
  - `should_branch_to_link` = latched to_link.
- `should_branch`, `write_condition` and `should_branch_to_link` are 0 in every other state. A failed condition leaves only the +1 increment.

## Timing
- Reset values: state IDLE, `fetch_req` 0, `decode_en` 0, `halt_temporarily_signal` 1, `should_branch` 0, `write_condition` 0, `should_branch_to_link` 0, `busy` 0.
- All outputs are registered or decoded from state only. There are no combinational input-to-output paths.
- Minimum instruction time is 4 cycles (FETCH 1, DECODE 1, EXECUTE 1, ADVANCE 1) when `fetch_ack` and `exec_done` are already high.
- Reset asserted mid-operation, including during ADVANCE: immediately forces IDLE and the halt state, so the PC never sees a partial advance.
- `halt_temporarily_signal` is 1 in every state except ADVANCE.

## Configuration
- `PC_SEQ_PERF_EN` defined adds:
  - Output `stall_cycles`, 32 bits: counts cycles spent in FETCH or EXECUTE beyond the first cycle of each. It saturates at 0xFFFFFFFF and is cleared by reset.
  - Output `instr_retired`, 32 bits: increments on each ADVANCE and wraps.
- Without the macro, neither port nor counter exists.

## Structure
- Shared package `pc_seq_pkg`:
  - State enum with encodings IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, ADVANCE=4.
  - Condition code constants COND_EQ..COND_NV.
  - NZCV bit-index constants.
- One sub-module, `cond_eval`: combinational, `instr_cond` plus `flags_nzcv` in, pass bit out. It is instantiated once.

## Test plan
- Reset held, then released with `fetch_ack` and `exec_done` tied high → states cycle IDLE, FETCH, DECODE, EXECUTE, ADVANCE; `halt_temporarily_signal` low exactly 1 cycle in every 4.
- Cond 0 (EQ) branch, flags 0b0100 → ADVANCE has `should_branch`=1 and `write_condition`=1. Same with flags 0b0000 → `write_condition`=0.
- Cond 10 (GE) across all 16 NZCV values → pass exactly when N==V. Cond 15 → never passes; cond 14 → always passes.
- `fetch_ack` delayed 5 cycles and `exec_done` delayed 3 cycles → instruction takes 10 cycles; halt stays 1 throughout FETCH/EXECUTE; with the macro, `stall_cycles` grows by 6.
- BX with `instr_to_link`=1, cond AL → ADVANCE has `should_branch_to_link`=1, `should_branch`=1, `write_condition`=1.
- `reset` asserted asynchronously mid-ADVANCE → same instant: halt=1 and branch outputs=0; after release, IDLE then FETCH.
